// File: rtl/vga_scan_if.sv
// rtl/vga_scan_if.sv - framebuffer, palette and VGA pin bundle for the scan-out stage
interface vga_scan_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_ren;
    logic [7:0]        fb_data;
    logic [7:0]        pal_addr;
    logic [11:0]       pal_color;
    logic [3:0]        vga_r;
    logic [3:0]        vga_g;
    logic [3:0]        vga_b;
    logic              vga_hsync;
    logic              vga_vsync;
    logic              frame_start;
    logic              in_vblank;

    modport master (
        output fb_addr, fb_ren, pal_addr,
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
        output frame_start, in_vblank,
        input  fb_data, pal_color
    );

    modport slave (
        input  fb_addr, fb_ren, pal_addr,
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
        input  frame_start, in_vblank,
        output fb_data, pal_color
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA timing counters with a 2-tick fetch/palette/pin pipeline
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit SYNC_POL = 1'b0,
    parameter int ADDR_W   = 19
) (
    input  logic      clk,
    input  logic      rst,
    vga_scan_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_L = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_L = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [31:0]   H_ACT_32 = 32'(H_ACTIVE);

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          pix_en;
    logic          h_wrap;
    logic          v_wrap;

    logic          active0;
    logic          hs0;
    logic          vs0;
    logic [31:0]   addr_full;

    logic [7:0]    idx_reg;
    logic          active1;
    logic          hs1;
    logic          vs1;
    logic [11:0]   rgb_q;
    logic          hsync_q;
    logic          vsync_q;
    logic          frame_q;

    assign pix_en = (div_cnt == DIV_LAST);
    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
            if (pix_en) begin
                if (h_wrap) begin
                    h_cnt <= '0;
                    v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 0: address and sync decode straight from the counters
    assign active0   = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
    assign hs0       = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs0       = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign addr_full = 32'(v_cnt) * H_ACT_32 + 32'(h_cnt);

    assign bus.fb_addr   = active0 ? addr_full[ADDR_W-1:0] : '0;
    assign bus.fb_ren    = active0;
    assign bus.in_vblank = (v_cnt >= V_ACT_L);

    // Stages 1 and 2: sync bits travel alongside the pixel so the pins stay aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg <= '0;
            active1 <= 1'b0;
            hs1     <= 1'b0;
            vs1     <= 1'b0;
            rgb_q   <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            frame_q <= 1'b0;
        end else begin
            frame_q <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                idx_reg <= bus.fb_data;
                active1 <= active0;
                hs1     <= hs0;
                vs1     <= vs0;
                rgb_q   <= active1 ? bus.pal_color : 12'h000;
                hsync_q <= hs1 ? SYNC_POL : ~SYNC_POL;
                vsync_q <= vs1 ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign bus.pal_addr    = idx_reg;
    assign bus.vga_r       = rgb_q[11:8];
    assign bus.vga_g       = rgb_q[7:4];
    assign bus.vga_b       = rgb_q[3:0];
    assign bus.vga_hsync   = hsync_q;
    assign bus.vga_vsync   = vsync_q;
    assign bus.frame_start = frame_q;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb/tb_vga_scan_ctrl.sv - scan-out bench on a shrunken raster with a per-cycle position model
module tb_vga_scan_ctrl;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int CD = 4, AW = 19;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   pal_mode = 0;
    int   fs_seen = 0;
    bit   chk_en = 1'b0;
    int   n;
    logic [7:0]  fb_q;
    logic [11:0] rgb;

    vga_scan_if #(.ADDR_W(AW)) bus();

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD), .SYNC_POL(1'b0), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    always @(posedge clk) fb_q <= bus.fb_addr[7:0];
    assign bus.fb_data = fb_q;

    function automatic logic [11:0] pal_fn(int mode, logic [7:0] a);
        case (mode)
            0:       return {4'h0, a};
            1:       return 12'hFFF;
            default: return {a[3:0], a[7:4], ~a[3:0]};
        endcase
    endfunction

    assign bus.pal_color = pal_fn(pal_mode, bus.pal_addr);
    assign rgb = {bus.vga_r, bus.vga_g, bus.vga_b};

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: after k pixel ticks the raster sits at k mod FRAME; pins show tick k-2
    task automatic step();
        int k, p, h, v, q, hh, vv;
        logic ea, eh, ev, efs, evb;
        logic [11:0] er;
        logic [31:0] eaddr;
        @(negedge clk);
        if (rst || !chk_en) return;
        if (bus.frame_start) fs_seen++;
        k = n / CD;
        p = k % FRAME;
        h = p % HT;
        v = p / HT;
        ea = (h < HA) && (v < VA);
        eaddr = ea ? v * HA + h : 0;
        if (k >= 2) begin
            q  = (k - 2) % FRAME;
            hh = q % HT;
            vv = q / HT;
            er = ((hh < HA) && (vv < VA)) ? pal_fn(pal_mode, 8'((vv * HA + hh) & 255)) : 12'h000;
            eh = !((hh >= HA + HF) && (hh < HA + HF + HS));
            ev = !((vv >= VA + VF) && (vv < VA + VF + VS));
        end else begin
            er = 12'h000;
            eh = 1'b1;
            ev = 1'b1;
        end
        efs = (n % CD == 0) && (k > 0) && (p == 0);
        evb = (v >= VA);
        check($sformatf("pins@%0d", n),
              {15'b0, rgb, bus.vga_hsync, bus.vga_vsync, bus.frame_start, bus.in_vblank, bus.fb_ren},
              {15'b0, er, eh, ev, efs, evb, ea});
        check($sformatf("addr@%0d", n), 32'(bus.fb_addr), eaddr);
    endtask

    task automatic run_to(int tick);
        int guard = 0;
        do begin
            step();
            guard++;
        end while (n != tick * CD && guard < 20000);
        if (n != tick * CD) check("run_to_timeout", n, tick * CD);
    endtask

    task automatic check_reset_pins(string tag);
        check({tag, "_rgb"},   rgb, 12'h000);
        check({tag, "_hsync"}, bus.vga_hsync, 1'b1);
        check({tag, "_vsync"}, bus.vga_vsync, 1'b1);
        check({tag, "_fs"},    bus.frame_start, 1'b0);
        check({tag, "_vb"},    bus.in_vblank, 1'b0);
        check({tag, "_ren"},   bus.fb_ren, 1'b1);
        check({tag, "_addr"},  32'(bus.fb_addr), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_pins("rst");

        // Segment A: identity palette, timing landmarks pinned by hand
        pal_mode = 0;
        rst = 1'b0;
        chk_en = 1'b1;
        run_to(7);   check("px5_rgb", rgb, 12'h005);
        run_to(11);  check("hs_pre", bus.vga_hsync, 1'b1);
        run_to(12);  check("hs_first", bus.vga_hsync, 1'b0);
        run_to(14);  check("hs_last", bus.vga_hsync, 1'b0);
        run_to(15);  check("hs_post", bus.vga_hsync, 1'b1);
        run_to(52);  check("addr_last_px", 32'(bus.fb_addr), 32'd31);
                     check("ren_last_px", bus.fb_ren, 1'b1);
        run_to(53);  check("addr_blank", 32'(bus.fb_addr), 32'd0);
                     check("ren_blank", bus.fb_ren, 1'b0);
        run_to(59);  check("vb_pre", bus.in_vblank, 1'b0);
        run_to(60);  check("vb_rise", bus.in_vblank, 1'b1);
        run_to(76);  check("vs_pre", bus.vga_vsync, 1'b1);
        run_to(77);  check("vs_first", bus.vga_vsync, 1'b0);
        run_to(106); check("vs_last", bus.vga_vsync, 1'b0);
        run_to(107); check("vs_post", bus.vga_vsync, 1'b1);
        run_to(120); check("fs_pulse", bus.frame_start, 1'b1);
                     check("vb_fall", bus.in_vblank, 1'b0);
        run_to(250);

        // Segment B: all-white palette, then an asynchronous reset mid-line
        #2 rst = 1'b1;
        #1 check_reset_pins("arst_a");
        pal_mode = 1;
        @(negedge clk);
        rst = 1'b0;
        run_to(2);  check("white_first", rgb, 12'hFFF);
        run_to(10); check("white_blank", rgb, 12'h000);
        run_to(36); check("mid_addr", 32'(bus.fb_addr), 32'd22);
                    check("mid_rgb", rgb, 12'hFFF);
        #2 rst = 1'b1;
        #1 check_reset_pins("arst_b");
        @(posedge clk);
        #1 check("held_addr", 32'(bus.fb_addr), 32'd0);

        // Segment C: scrambled palette, frame_start counted across two frames
        pal_mode = 2;
        @(negedge clk);
        rst = 1'b0;
        fs_seen = 0;
        run_to(7);   check("px5_mode2", rgb, 12'h50A);
        run_to(119); check("fs_none_yet", fs_seen, 0);
        run_to(2 * FRAME + 5);
        check("fs_count", fs_seen, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Pixel-timing and scan-out stage that drives the VGA connector.
- Generates horizontal and vertical counters plus hsync/vsync from the system clock via a pixel-enable divider.
- Fetches an 8-bit colour index per pixel from the framebuffer and presents it to the palette read port (index in, 12-bit colour out, combinational).
- Registers the returned colour onto the RGB pins, with sync signals aligned to the pixel data.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (≥2)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- ADDR_W, 19, framebuffer address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- fb_addr  out  ADDR_W  framebuffer read address
- fb_ren  out  1  framebuffer read enable
- fb_data  in  8  framebuffer read data (colour index)
- pal_addr  out  8  palette read index
- pal_color  in  12  palette colour {R[11:8],G[7:4],B[3:0]}, combinational from pal_addr
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- frame_start  out  1  one-clk pulse at start of each frame
- in_vblank  out  1  high while v_cnt ≥ V_ACTIVE

Behaviour:
- Clock and reset:
  - Single clock. Reset is asynchronous and active-high on rst; all registers clear immediately on assertion.
  - Reset values: div_cnt=0, h_cnt=0, v_cnt=0, idx_reg=0, pipeline valid bits=0, vga_r/g/b=0, vga_hsync=vga_vsync=~SYNC_POL, frame_start=0.
- Pixel enable:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 when div_cnt==CLK_DIV-1.
  - All state below except div_cnt advances only on clk edges where pix_en=1.
- Counters:
  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - h_cnt increments and wraps H_TOTAL-1→0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1→0.
- Stage 0 (combinational from counters):
  - active0=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
  - hs0 asserted when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs0 analogous on v_cnt.
  - fb_addr = active0 ? v_cnt*H_ACTIVE+h_cnt : 0, truncated to ADDR_W.
  - fb_ren = active0.
  - Framebuffer must return fb_data within CLK_DIV-1 clk cycles (synchronous RAM, 1-cycle read).
- Stage 1 (on pix_en): idx_reg<=fb_data; active1<=active0; hs1<=hs0; vs1<=vs0. pal_addr=idx_reg (direct wire).
- Stage 2 (on pix_en):
  - {vga_r,vga_g,vga_b} <= active1 ? pal_color : 12'h000.
  - vga_hsync <= hs1 ? SYNC_POL : ~SYNC_POL; vga_vsync likewise from vs1.
- Latency: pins reflect counter position (h,v) exactly 2 pixel ticks later. RGB is always 0 during blanking, including the first 2 ticks after reset.
- frame_start: 1 for exactly one clk on the pix_en edge where h_cnt and v_cnt both wrap to 0; otherwise 0.
- in_vblank: combinational, (v_cnt ≥ V_ACTIVE).
- Palette writes by the CPU on the same cycle as a read: pal_color reflects the pre-write contents until the write edge. No hazard handling in this block.
- Reset mid-frame: counters restart at (0,0) with no frame_start pulse on release. The first frame_start occurs at the next full wrap.

Test Plan:
- Line/frame counts: release reset, run → hsync period 800 pixel ticks (3200 clk); vsync period 525 lines (1,680,000 clk); hsync low for h 656..751, vsync low for lines 490..491 (SYNC_POL=0).
- Pipeline alignment: fb model returns fb_data = fb_addr[7:0]; palette model returns {4'h0,addr} → at pin tick t, RGB equals low 8 bits of pixel (h,v) presented at tick t-2; pixel (5,0) shows 12'h005.
- Blanking: palette returns 12'hFFF for all indices → RGB=12'hFFF only for h<640, v<480 (shifted by 2 ticks); otherwise 12'h000.
- Address arithmetic: at (h=639,v=479), fb_addr=307199 and fb_ren=1; at h=640, fb_addr=0 and fb_ren=0.
- frame_start/in_vblank: frame_start pulses once per 525 lines, width 1 clk; in_vblank rises at v=480 and falls at v=0.
- Async reset mid-line at (h=300,v=100) between clk edges → outputs take reset values immediately; after release, counters resume from (0,0) and no frame_start occurs until the next wrap.
